// File: rtl/usb_wb_cmd_master.sv
// usb_wb_cmd_master
// Wishbone initiator for the co-simulation harness. Byte-wide register
// commands are queued in a small FIFO and replayed one at a time on an 8-bit
// Wishbone port. Each command produces exactly one response on a valid/ready
// channel.
// Optional feature: define USB_WB_MASTER_TIMEOUT_EN to build the no-ack
// timeout counter and the error response path. Without it, a request waits
// for ack_i indefinitely and rsp_err_o is tied low.
module usb_wb_cmd_master #(
   parameter int CMD_FIFO_AW    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_we_i,
   input  logic [7:0] cmd_addr_i,
   input  logic [7:0] cmd_data_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_data_o,
   output logic       rsp_err_o,
   output logic       busy_o,
   output logic [7:0] address_o,
   output logic [7:0] data_o,
   input  logic [7:0] data_i,
   output logic       we_o,
   output logic       strobe_o,
   input  logic       ack_i
);

   // Reject an out-of-range timeout at elaboration rather than silently
   // truncating it to the 16-bit counter.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("usb_wb_cmd_master: TIMEOUT_CYCLES must be within 1..65535");
   end

   localparam int DEPTH = 1 << CMD_FIFO_AW;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;

   // FIFO entry layout: {we, addr[7:0], data[7:0]}
   logic [16:0]          fifo_mem [DEPTH];
   logic [CMD_FIFO_AW:0] wr_ptr;
   logic [CMD_FIFO_AW:0] rd_ptr;
   logic [CMD_FIFO_AW:0] wr_ptr_next;
   logic [CMD_FIFO_AW:0] rd_ptr_next;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic [16:0]          head;
   logic                 head_we;
   logic [7:0]           head_addr;
   logic [7:0]           head_data;

   logic [1:0]           state;
   logic [1:0]           state_next;
   logic                 timeout_hit;

   // The extra pointer MSB distinguishes full from empty when the index bits match.
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[CMD_FIFO_AW] != rd_ptr[CMD_FIFO_AW]) &&
                        (wr_ptr[CMD_FIFO_AW-1:0] == rd_ptr[CMD_FIFO_AW-1:0]);
   assign cmd_ready_o = !fifo_full;

   assign push        = cmd_valid_i && !fifo_full;
   assign pop         = (state == ST_IDLE) && !fifo_empty;
   assign wr_ptr_next = wr_ptr + (CMD_FIFO_AW+1)'(push);
   assign rd_ptr_next = rd_ptr + (CMD_FIFO_AW+1)'(pop);

   assign head        = fifo_mem[rd_ptr[CMD_FIFO_AW-1:0]];
   assign head_we     = head[16];
   assign head_addr   = head[15:8];
   assign head_data   = head[7:0];

   // Command storage write port.
   // NOTE: the storage array has no reset; only the pointers need one, and
   // leaving it out keeps the array mappable onto plain flops or LUT RAM.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr[CMD_FIFO_AW-1:0]] <= {cmd_we_i, cmd_addr_i, cmd_data_i};
      end
   end

   // FIFO pointers; a simultaneous push and pop moves both, keeping the count.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
      end
   end

`ifdef USB_WB_MASTER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0] tmo_cnt;
   logic [15:0] tmo_cnt_inc;

   // Abort on the edge where the count of un-acked strobe cycles reaches the limit.
   assign tmo_cnt_inc = tmo_cnt + 16'd1;
   assign timeout_hit = (state == ST_REQ) && !ack_i && (tmo_cnt_inc == TIMEOUT_LIMIT);

   // Count strobe cycles without ack; restart whenever a new request is launched.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt <= '0;
      end else if (pop) begin
         tmo_cnt <= '0;
      end else if (state == ST_REQ && !ack_i) begin
         tmo_cnt <= tmo_cnt_inc;
      end
   end

   // Error flag: cleared by an ack, set by an abort, held otherwise.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rsp_err_o <= 1'b0;
      end else if (state == ST_REQ) begin
         if (ack_i) begin
            rsp_err_o <= 1'b0;
         end else if (timeout_hit) begin
            rsp_err_o <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign rsp_err_o   = 1'b0;
`endif

   // Next-state decode; ack_i only matters while a request is on the bus.
   // NOTE: state_next gets a default before the case so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (!fifo_empty)           state_next = ST_REQ;
         ST_REQ:  if (ack_i || timeout_hit)  state_next = ST_RSP;
         ST_RSP:  if (rsp_ready_i)           state_next = ST_IDLE;
         default:                            state_next = ST_IDLE;
      endcase
   end

   // Bus/response registers; address, data and we only change when a command
   // is popped, so they are stable for the whole strobe.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= ST_IDLE;
         strobe_o    <= 1'b0;
         we_o        <= 1'b0;
         address_o   <= 8'h00;
         data_o      <= 8'h00;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= 8'h00;
         busy_o      <= 1'b0;
      end else begin
         state  <= state_next;
         busy_o <= (state_next != ST_IDLE) || (wr_ptr_next != rd_ptr_next);
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  we_o      <= head_we;
                  address_o <= head_addr;
                  data_o    <= head_we ? head_data : 8'h00;
                  strobe_o  <= 1'b1;
               end
            end
            ST_REQ: begin
               if (ack_i) begin
                  rsp_data_o  <= we_o ? 8'h00 : data_i;
                  strobe_o    <= 1'b0;
                  rsp_valid_o <= 1'b1;
               end else if (timeout_hit) begin
                  rsp_data_o  <= 8'hFF;
                  strobe_o    <= 1'b0;
                  rsp_valid_o <= 1'b1;
               end
            end
            ST_RSP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
               end
            end
            default: begin
               strobe_o    <= 1'b0;
               rsp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
